// File: rtl/ps2_keyboard_pkg.sv
// Shared constants, FSM state type and helpers for the PS/2 keyboard receiver.
package ps2_keyboard_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_M     = 8'h3A;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    localparam int KE_VALID = 10;
    localparam int KE_EXT   = 9;
    localparam int KE_BRK   = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Keyboard status/ack bytes that carry no key and reset prefix state.
    function automatic logic is_silent(input logic [7:0] b);
        logic s;
        unique case (b)
            8'hE1, 8'hAA, 8'hFA, 8'hFE,
            8'hEE, 8'h00, 8'hFF: s = 1'b1;
            default:             s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ps2_keyboard_filter.sv
// Synchronizers, glitch filter and falling-edge detect for the PS/2 pins.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic ps2_c,
    input  logic ps2_d,
    output logic fall,
    output logic d_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    c_pipe;
    logic [1:0]    d_pipe;
    logic          c_filt;
    logic [CW-1:0] cnt;
    logic          flip;

    // Flip after FILTER_LEN consecutive samples disagreeing with c_filt.
    assign flip   = (c_pipe[1] != c_filt) && (cnt == CW'(FILTER_LEN - 1));
    assign fall   = flip & c_filt;
    assign d_sync = d_pipe[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_pipe <= 2'b11;
            d_pipe <= 2'b11;
            c_filt <= 1'b1;
            cnt    <= '0;
        end else begin
            c_pipe <= {c_pipe[0], ps2_c};
            d_pipe <= {d_pipe[0], ps2_d};
            if (c_pipe[1] == c_filt) begin
                cnt <= '0;
            end else if (flip) begin
                c_filt <= c_pipe[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: deframes scan codes and folds E0/F0 prefixes
// into a single key_event strobe for the key decoder.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ps2_c,
    input  logic        ps2_d,
    output logic [10:0] key_event,
    output logic        frame_err
);

    localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);

    ps2_state_e    state;
    logic          fall;
    logic          d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          byte_done;
    logic          ext;
    logic          brk;
    logic          to_hit;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk   (clk),
        .rstn  (rstn),
        .ps2_c (ps2_c),
        .ps2_d (ps2_d),
        .fall  (fall),
        .d_sync(d)
    );

    assign to_hit = (state != IDLE) && !fall && (tcnt == TW'(TO_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
            byte_done <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            key_event <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err           <= 1'b0;
            byte_done           <= 1'b0;
            key_event[KE_VALID] <= 1'b0;

            // shreg is stable here: the FSM sits in IDLE after STOP.
            if (byte_done) begin
                if (shreg == PFX_EXT) begin
                    ext <= 1'b1;
                end else if (shreg == PFX_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!is_silent(shreg))
                        key_event <= {1'b1, ext, brk, bitrev8(shreg)};
                end
            end

            if (state == IDLE || fall) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;

            if (to_hit) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!d) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {d, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= d;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (d && (^{shreg, par})) begin
                            byte_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: directed PS/2 frames, queued expectations.
module tb_ps2_keyboard;

    localparam int F      = 8;
    localparam int CLK_HZ = 1000000;
    localparam int TO_US  = 200;
    localparam int TO_CYC = CLK_HZ / 1000000 * TO_US;
    localparam int HALF   = 20;

    logic        clk;
    logic        rstn;
    logic        ps2_c;
    logic        ps2_d;
    logic [10:0] key_event;
    logic        frame_err;

    int          cyc;
    int          last_stop_cyc;
    int          n_cmp;
    int          n_err;
    logic [10:0] exp_q[$];
    bit          err_q[$];
    logic        err_prev;

    ps2_keyboard #(
        .CLK_HZ    (CLK_HZ),
        .FILTER_LEN(F),
        .TIMEOUT_US(TO_US)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ps2_c    (ps2_c),
        .ps2_d    (ps2_d),
        .key_event(key_event),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch, input bit stop);
        ps2_d = b;
        if (glitch) begin
            wait_clk(4);
            ps2_c = 1'b0;
            wait_clk(F - 1);
            ps2_c = 1'b1;
            wait_clk(HALF - 4 - (F - 1));
        end else begin
            wait_clk(HALF);
        end
        ps2_c = 1'b0;
        if (stop) last_stop_cyc = cyc;
        wait_clk(HALF);
        ps2_c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input int glitch_bit);
        send_bit(1'b0, glitch_bit == 0, 1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i], glitch_bit == i + 1, 1'b0);
        send_bit((~^b) ^ bad_par, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        ps2_d = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, -1);
    endtask

    task automatic partial(input logic [7:0] b, input int nbits);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++)
            send_bit(b[i], 1'b0, 1'b0);
        ps2_d = 1'b1;
    endtask

    task automatic expect_ev(input logic [10:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_quiet(input string name);
        n_cmp++;
        if (key_event !== 11'h000 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL %s: key_event=%h frame_err=%b, required 000/0",
                     name, key_event, frame_err);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes an output.
    initial begin
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (key_event[10] === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got %h, required none",
                             key_event);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    if (key_event !== e) begin
                        n_err++;
                        $display("FAIL event: got %h, required %h",
                                 key_event, e);
                    end
                    n_cmp++;
                    if (cyc - last_stop_cyc != F + 3) begin
                        n_err++;
                        $display("FAIL latency: got %0d, required %0d",
                                 cyc - last_stop_cyc, F + 3);
                    end
                end
            end
            if (frame_err === 1'b1) begin
                n_cmp++;
                if (err_q.size() == 0 || err_prev) begin
                    n_err++;
                    $display("FAIL frame_err: got pulse (prev=%b), required %0d pending",
                             err_prev, err_q.size());
                end else begin
                    void'(err_q.pop_front());
                end
            end
            err_prev = frame_err;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got %0d cycles, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_stop_cyc = 0;
        ps2_c = 1'b1;
        ps2_d = 1'b1;
        rstn  = 1'b0;
        wait_clk(3);
        check_quiet("reset_state");
        rstn = 1'b1;
        wait_clk(10);

        expect_ev(11'h4B8);
        good(8'h1D);

        expect_ev(11'h6AE);
        good(8'hE0); good(8'h75);
        expect_ev(11'h7AE);
        good(8'hE0); good(8'hF0); good(8'h75);

        expect_ev(11'h5B8);
        good(8'hF0); good(8'h1D);
        expect_ev(11'h494);
        good(8'h29);

        expect_ev(11'h4B8);
        good(8'hE0); good(8'hAA); good(8'h1D);

        err_q.push_back(1'b1);
        send_frame(8'h29, 1'b1, -1);
        expect_ev(11'h4B8);
        good(8'h1D);

        expect_ev(11'h438);
        send_frame(8'h1C, 1'b0, 3);

        err_q.push_back(1'b1);
        partial(8'h23, 5);
        wait_clk(TO_CYC + 60);
        expect_ev(11'h4C4);
        good(8'h23);

        partial(8'h3A, 4);
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_clk(1);
            check_quiet("during_reset");
        end
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_clk(1);
            check_quiet("after_reset");
        end
        wait_clk(HALF);
        expect_ev(11'h45C);
        good(8'h3A);

        wait_clk(50);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL events_pending: got %0d, required 0", exp_q.size());
        end
        n_cmp++;
        if (err_q.size() != 0) begin
            n_err++;
            $display("FAIL errors_pending: got %0d, required 0", err_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
